// File: rtl/epi_tracer_pkg.sv
// Shared encodings for the tracer LCI queue: FSM states and push/pull cases.
package epi_tracer_pkg;

  // Controller states (2-bit, kept as plain constants for legacy tooling)
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Per-cycle transfer case, encoded as {push_fire, pull_fire}
  localparam logic [1:0] OP_NN = 2'b00;
  localparam logic [1:0] OP_NP = 2'b01;
  localparam logic [1:0] OP_PN = 2'b10;
  localparam logic [1:0] OP_PP = 2'b11;

endpackage

// File: rtl/epi_tracer_lci_queue_cell.sv
// Next-state logic for one shift-queue entry (valid + LCI bit).
module epi_tracer_lci_queue_cell
  import epi_tracer_pkg::*;
(
  input  logic push_fire,
  input  logic pull_fire,
  input  logic wr_sel,
  input  logic push_last,
  input  logic clear,
  input  logic nbr_valid,
  input  logic nbr_lci,
  input  logic cur_valid,
  input  logic cur_lci,
  output logic nxt_valid,
  output logic nxt_lci
);

  // Hold, shift from the younger neighbour, or capture the pushed child
  always_comb begin
    nxt_valid = cur_valid;
    nxt_lci   = cur_lci;
    if (clear) begin
      nxt_valid = 1'b0;
      nxt_lci   = 1'b0;
    end else begin
      case ({push_fire, pull_fire})
        OP_NP: begin
          nxt_valid = nbr_valid;
          nxt_lci   = nbr_lci;
        end
        OP_PN: begin
          if (wr_sel) begin
            nxt_valid = 1'b1;
            nxt_lci   = push_last;
          end
        end
        OP_PP: begin
          if (wr_sel) begin
            nxt_valid = 1'b1;
            nxt_lci   = push_last;
          end else begin
            nxt_valid = nbr_valid;
            nxt_lci   = nbr_lci;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/epi_tracer_lci_queue_ctrl.sv
// LCI queue: shift-queue storage of child instructions with group-gated pulls
// and a flush sequence that drains complete groups and drops an open one.
module epi_tracer_lci_queue_ctrl
  import epi_tracer_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_valid_i,
  input  logic             push_last_i,
  output logic             push_ready_o,
  output logic             pull_valid_o,
  input  logic             pull_ready_i,
  output logic             pull_last_o,
  output logic             parent_done_o,
  input  logic             flush_i,
  output logic             flush_done_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] groups_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             open_group_o,
  output logic [DEPTH-1:0] valid_vec_o,
  output logic [DEPTH-1:0] lci_vec_o
);

  logic [1:0]       state_q, state_d;
  logic [DEPTH-1:0] valid_q, lci_q, valid_d, lci_d;
  logic [DEPTH:0]   valid_ext, lci_ext;
  logic [CNT_W-1:0] count_q, groups_q, wr_idx;
  logic             push_fire, pull_fire, clear;
  logic             open_group;

  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign push_ready_o  = (state_q == ST_RUN) && !full_o;
  assign pull_valid_o  = valid_q[0] && (groups_q != '0);
  assign pull_last_o   = lci_q[0];
  assign push_fire     = push_valid_i && push_ready_o;
  assign pull_fire     = pull_valid_o && pull_ready_i;
  assign parent_done_o = pull_fire && lci_q[0];
  assign flush_done_o  = (state_q == ST_DONE);
  assign clear         = (state_q == ST_FLUSH) && (groups_q == '0) && (count_q != '0);
  assign wr_idx        = pull_fire ? (count_q - CNT_W'(1)) : count_q;
  assign count_o       = count_q;
  assign groups_o      = groups_q;
  assign valid_vec_o   = valid_q;
  assign lci_vec_o     = lci_q & valid_q;
  assign open_group_o  = open_group;
  assign valid_ext     = {1'b0, valid_q};
  assign lci_ext       = {1'b0, lci_q};

  // One next-state cell per entry; the top entry shifts in an empty slot
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    epi_tracer_lci_queue_cell u_cell (
      .push_fire (push_fire),
      .pull_fire (pull_fire),
      .wr_sel    (wr_idx == CNT_W'(i)),
      .push_last (push_last_i),
      .clear     (clear),
      .nbr_valid (valid_ext[i+1]),
      .nbr_lci   (lci_ext[i+1]),
      .cur_valid (valid_q[i]),
      .cur_lci   (lci_q[i]),
      .nxt_valid (valid_d[i]),
      .nxt_lci   (lci_d[i])
    );
  end

  // The youngest valid entry decides whether a group is still open
  always_comb begin
    open_group = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) open_group = !lci_q[i];
    end
  end

  // Flush sequencing: drain complete groups, drop the open tail, pulse done
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_i) state_d = ST_FLUSH;
      ST_FLUSH: if (count_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // State, storage and occupancy/group counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      valid_q  <= '0;
      lci_q    <= '0;
      count_q  <= '0;
      groups_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lci_q   <= lci_d;
      if (clear) begin
        count_q  <= '0;
        groups_q <= '0;
      end else begin
        case ({push_fire, pull_fire})
          OP_PN:   count_q <= count_q + CNT_W'(1);
          OP_NP:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
        groups_q <= groups_q + CNT_W'(push_fire && push_last_i)
                             - CNT_W'(pull_fire && lci_q[0]);
      end
    end
  end

endmodule

// File: tb/tb_epi_tracer_lci_queue_ctrl.sv
// Directed self-checking bench for the LCI queue controller (DEPTH=4).
module tb_epi_tracer_lci_queue_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             push_valid_i, push_last_i, pull_ready_i, flush_i;
  logic             push_ready_o, pull_valid_o, pull_last_o, parent_done_o;
  logic             flush_done_o, full_o, empty_o, open_group_o;
  logic [CNT_W-1:0] count_o, groups_o;
  logic [DEPTH-1:0] valid_vec_o, lci_vec_o;

  int checks   = 0;
  int failures = 0;

  epi_tracer_lci_queue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_valid_i  (push_valid_i),
    .push_last_i   (push_last_i),
    .push_ready_o  (push_ready_o),
    .pull_valid_o  (pull_valid_o),
    .pull_ready_i  (pull_ready_i),
    .pull_last_o   (pull_last_o),
    .parent_done_o (parent_done_o),
    .flush_i       (flush_i),
    .flush_done_o  (flush_done_o),
    .count_o       (count_o),
    .groups_o      (groups_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .open_group_o  (open_group_o),
    .valid_vec_o   (valid_vec_o),
    .lci_vec_o     (lci_vec_o)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk_i = ~clk_i;

  // Drive inputs mid-cycle and let combinational outputs settle
  task automatic applyStimulus(input logic pv, input logic pl, input logic pr, input logic fl);
    push_valid_i = pv;
    push_last_i  = pl;
    pull_ready_i = pr;
    flush_i      = fl;
    #1;
  endtask

  // Advance past the next rising edge, sampling well away from it
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push_one(input logic last);
    applyStimulus(1'b1, last, 1'b0, 1'b0);
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (push_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_push_ready got=%b exp=1", push_ready_o); end
    checks++; if (pull_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_pull_valid got=%b exp=0", pull_valid_o); end
    checks++; if (flush_done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush_done got=%b exp=0", flush_done_o); end
    checks++; if ({full_o, empty_o, open_group_o} !== 3'b010) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=010", {full_o, empty_o, open_group_o}); end
    checks++; if ({count_o, groups_o} !== 6'd0) begin failures++; $display("[TB] FAIL reset_counts got=%0d/%0d exp=0/0", count_o, groups_o); end
    checks++; if ({valid_vec_o, lci_vec_o} !== 8'h00) begin failures++; $display("[TB] FAIL reset_vecs got=%h exp=00", {valid_vec_o, lci_vec_o}); end
  endtask

  task automatic test_group_pull();
    push_one(1'b0); push_one(1'b0); push_one(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 3'd3 || groups_o !== 3'd1) begin failures++; $display("[TB] FAIL grp_counts got=%0d/%0d exp=3/1", count_o, groups_o); end
    checks++; if (lci_vec_o !== 4'b0100 || valid_vec_o !== 4'b0111) begin failures++; $display("[TB] FAIL grp_vecs got lci=%b val=%b exp 0100/0111", lci_vec_o, valid_vec_o); end
    checks++; if (pull_valid_o !== 1'b1 || open_group_o !== 1'b0) begin failures++; $display("[TB] FAIL grp_pull_valid got=%b open=%b exp=1/0", pull_valid_o, open_group_o); end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (pull_valid_o !== 1'b1 || parent_done_o !== (k == 2) || pull_last_o !== (k == 2)) begin
        failures++; $display("[TB] FAIL grp_pull%0d got valid=%b done=%b last=%b exp 1/%0d/%0d", k, pull_valid_o, parent_done_o, pull_last_o, k == 2, k == 2);
      end
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (empty_o !== 1'b1 || count_o !== 3'd0 || groups_o !== 3'd0 || pull_valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL grp_drained got empty=%b cnt=%0d grp=%0d pv=%b exp 1/0/0/0", empty_o, count_o, groups_o, pull_valid_o);
    end
  endtask

  task automatic test_open_group();
    push_one(1'b0); push_one(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (pull_valid_o !== 1'b0 || open_group_o !== 1'b1 || count_o !== 3'd2) begin
      failures++; $display("[TB] FAIL open_blocked got pv=%b open=%b cnt=%0d exp 0/1/2", pull_valid_o, open_group_o, count_o);
    end
    tick();
    checks++; if (count_o !== 3'd2 || pull_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL open_hold got cnt=%0d pv=%b exp 2/0", count_o, pull_valid_o); end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (pull_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL open_close_same got pv=%b exp=0", pull_valid_o); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (pull_valid_o !== 1'b1 || groups_o !== 3'd1 || count_o !== 3'd3 || open_group_o !== 1'b0) begin
      failures++; $display("[TB] FAIL open_closed got pv=%b grp=%0d cnt=%0d open=%b exp 1/1/3/0", pull_valid_o, groups_o, count_o, open_group_o);
    end
    tick(); tick(); tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 3'd0 || groups_o !== 3'd0) begin failures++; $display("[TB] FAIL open_drained got=%0d/%0d exp=0/0", count_o, groups_o); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) push_one(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (full_o !== 1'b1 || push_ready_o !== 1'b0 || count_o !== 3'd4 || groups_o !== 3'd4) begin
      failures++; $display("[TB] FAIL full_flags got full=%b pr=%b cnt=%0d grp=%0d exp 1/0/4/4", full_o, push_ready_o, count_o, groups_o);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (push_ready_o !== 1'b0 || pull_valid_o !== 1'b1 || parent_done_o !== 1'b1) begin
      failures++; $display("[TB] FAIL full_simul got pr=%b pv=%b done=%b exp 0/1/1", push_ready_o, pull_valid_o, parent_done_o);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 3'd3 || groups_o !== 3'd3 || lci_vec_o !== 4'b0111 || valid_vec_o !== 4'b0111) begin
      failures++; $display("[TB] FAIL full_refused got cnt=%0d grp=%0d lci=%b val=%b exp 3/3/0111/0111", count_o, groups_o, lci_vec_o, valid_vec_o);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    push_one(1'b1); push_one(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (parent_done_o !== 1'b1 || push_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_fire got done=%b pr=%b exp 1/1", parent_done_o, push_ready_o); end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 3'd2 || groups_o !== 3'd1 || lci_vec_o !== 4'b0001 || valid_vec_o !== 4'b0011 || open_group_o !== 1'b1) begin
      failures++; $display("[TB] FAIL b2b_state got cnt=%0d grp=%0d lci=%b val=%b open=%b exp 2/1/0001/0011/1", count_o, groups_o, lci_vec_o, valid_vec_o, open_group_o);
    end
    do_reset();
  endtask

  task automatic test_flush();
    push_one(1'b1); push_one(1'b0); push_one(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (push_ready_o !== 1'b0 || pull_valid_o !== 1'b1 || parent_done_o !== 1'b1) begin
      failures++; $display("[TB] FAIL flush_pull got pr=%b pv=%b done=%b exp 0/1/1", push_ready_o, pull_valid_o, parent_done_o);
    end
    tick();
    checks++; if (count_o !== 3'd2 || groups_o !== 3'd0 || pull_valid_o !== 1'b0 || parent_done_o !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_open got cnt=%0d grp=%0d pv=%b done=%b exp 2/0/0/0", count_o, groups_o, pull_valid_o, parent_done_o);
    end
    tick();
    checks++; if (count_o !== 3'd0 || valid_vec_o !== 4'b0000 || flush_done_o !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_clear got cnt=%0d val=%b fd=%b exp 0/0000/0", count_o, valid_vec_o, flush_done_o);
    end
    tick();
    checks++; if (flush_done_o !== 1'b1 || push_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_done got fd=%b pr=%b exp 1/0", flush_done_o, push_ready_o); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (flush_done_o !== 1'b0 || push_ready_o !== 1'b1 || count_o !== 3'd0) begin
      failures++; $display("[TB] FAIL flush_back_run got fd=%b pr=%b cnt=%0d exp 0/1/0", flush_done_o, push_ready_o, count_o);
    end
  endtask

  task automatic test_reset_in_flush();
    int seen_done;
    push_one(1'b0); push_one(1'b0); push_one(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (push_ready_o !== 1'b0 || count_o !== 3'd3) begin failures++; $display("[TB] FAIL rstfl_in_flush got pr=%b cnt=%0d exp 0/3", push_ready_o, count_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    checks++; if (count_o !== 3'd0 || push_ready_o !== 1'b1 || empty_o !== 1'b1) begin
      failures++; $display("[TB] FAIL rstfl_state got cnt=%0d pr=%b empty=%b exp 0/1/1", count_o, push_ready_o, empty_o);
    end
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      if (flush_done_o === 1'b1) seen_done++;
      tick();
    end
    checks++; if (seen_done != 0) begin failures++; $display("[TB] FAIL rstfl_no_done got pulses=%0d exp=0", seen_done); end
  endtask

  // Run every scenario in order, then report
  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_group_pull();
    test_open_group();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_in_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
